// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_pkg                                                          |
// | Shared opcode/funct3 constants and the memory alignment-fault check.   |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
package mem_stage_pkg;

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;

  localparam logic [2:0] c_f3_lb  = 3'b000;
  localparam logic [2:0] c_f3_lh  = 3'b001;
  localparam logic [2:0] c_f3_lw  = 3'b010;
  localparam logic [2:0] c_f3_lbu = 3'b100;
  localparam logic [2:0] c_f3_lhu = 3'b101;
  localparam logic [2:0] c_f3_sb  = 3'b000;
  localparam logic [2:0] c_f3_sh  = 3'b001;
  localparam logic [2:0] c_f3_sw  = 3'b010;

  // Undefined funct3 encodings are reported the same way as misalignment.
  function automatic logic mem_fault(input logic is_store, input logic [2:0] funct,
                                     input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    if (is_store) begin
      case (funct)
        c_f3_sb: bad = 1'b0;
        c_f3_sh: bad = addr_lo[0];
        c_f3_sw: bad = (addr_lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (funct)
        c_f3_lb, c_f3_lbu: bad = 1'b0;
        c_f3_lh, c_f3_lhu: bad = addr_lo[0];
        c_f3_lw:           bad = (addr_lo != 2'b00);
        default:           bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_align                                                              |
// | Store byte-lane shift, write-mask generation, load extract/extend.     |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_dout,
  output logic [3:0]      o_we_mask,
  output logic [XLEN-1:0] o_din,
  output logic [XLEN-1:0] o_load_data
);

  logic [4:0]  w_shamt;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shamt = {i_addr_lo, 3'b000};
  assign o_din   = i_rs2_data << w_shamt;
  assign w_byte  = i_dout[w_shamt +: 8];
  assign w_half  = i_addr_lo[1] ? i_dout[XLEN-1:XLEN/2] : i_dout[XLEN/2-1:0];

  always_comb begin
    o_we_mask = 4'b0000;
    case (i_funct)
      c_f3_sb: o_we_mask = 4'b0001 << i_addr_lo;
      c_f3_sh: o_we_mask = 4'b0011 << i_addr_lo;
      c_f3_sw: o_we_mask = 4'b1111;
      default: o_we_mask = 4'b0000;
    endcase
  end

  always_comb begin
    o_load_data = i_dout;
    case (i_funct)
      c_f3_lb:  o_load_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      c_f3_lh:  o_load_data = {{(XLEN-16){w_half[15]}}, w_half};
      c_f3_lbu: o_load_data = {{(XLEN-8){1'b0}}, w_byte};
      c_f3_lhu: o_load_data = {{(XLEN-16){1'b0}}, w_half};
      default:  o_load_data = i_dout;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage                                                              |
// | Pipeline memory stage: ALU pass-through, data-cache load/store FSM.    |
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [4:0]      in_rd,
  output logic [XLEN-1:0] dcache_addr,
  output logic            dcache_re,
  output logic [3:0]      dcache_we,
  output logic [XLEN-1:0] dcache_din,
  input  logic [XLEN-1:0] dcache_dout,
  input  logic            dcache_stall,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misalign
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_wait = 2'd2;

  logic [1:0]      r_state;
  logic            r_is_load;
  logic [2:0]      r_funct;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_rs2;
  logic [4:0]      r_rd;
  logic            r_wb_valid;
  logic            r_wb_we;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_misalign;

  logic            w_accept;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_fault;
  logic [3:0]      w_we_mask;
  logic [XLEN-1:0] w_din;
  logic [XLEN-1:0] w_load_data;

  assign in_ready   = Reset_n & (r_state == c_st_idle);
  assign w_accept   = in_valid & in_ready;
  assign w_is_load  = (in_opcode == c_op_load);
  assign w_is_store = (in_opcode == c_op_store);
  assign w_fault    = mem_fault(w_is_store, in_funct, in_alu_out[1:0]);

  mem_align #(.XLEN(XLEN)) u_mem_align (
    .i_funct     (r_funct),
    .i_addr_lo   (r_addr[1:0]),
    .i_rs2_data  (r_rs2),
    .i_dout      (dcache_dout),
    .o_we_mask   (w_we_mask),
    .o_din       (w_din),
    .o_load_data (w_load_data)
  );

  // Cache strobes decode straight from state so reset drops them asynchronously.
  assign dcache_addr = {r_addr[XLEN-1:2], 2'b00};
  assign dcache_re   = (r_state == c_st_req) & r_is_load;
  assign dcache_we   = ((r_state == c_st_req) & ~r_is_load) ? w_we_mask : 4'b0000;
  assign dcache_din  = w_din;
  assign wb_valid    = r_wb_valid;
  assign wb_we       = r_wb_we;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign misalign    = r_misalign;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= c_st_idle;
      r_is_load  <= 1'b0;
      r_funct    <= 3'b000;
      r_addr     <= '0;
      r_rs2      <= '0;
      r_rd       <= 5'd0;
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_we    <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            if (!(w_is_load || w_is_store)) begin
              r_wb_valid <= 1'b1;
              r_wb_we    <= 1'b1;
              r_wb_rd    <= in_rd;
              r_wb_data  <= in_alu_out;
            end else if (w_fault) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= in_rd;
              r_wb_data  <= in_alu_out;
              r_misalign <= 1'b1;
            end else begin
              r_state   <= c_st_req;
              r_is_load <= w_is_load;
              r_funct   <= in_funct;
              r_addr    <= in_alu_out;
              r_rs2     <= in_rs2_data;
              r_rd      <= in_rd;
            end
          end
        end
        c_st_req: begin
          if (!dcache_stall) begin
            if (r_is_load) begin
              r_state <= c_st_wait;
            end else begin
              r_state    <= c_st_idle;
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_data  <= r_addr;
            end
          end
        end
        c_st_wait: begin
          if (!dcache_stall) begin
            r_state    <= c_st_idle;
            r_wb_valid <= 1'b1;
            r_wb_we    <= (r_rd != 5'd0);
            r_wb_rd    <= r_rd;
            r_wb_data  <= w_load_data;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_stage                                                           |
// | Randomized self-checking bench for mem_stage against a reference model.|
// | Rev 1.0                                                                |
// +----------------------------------------------------------------------+
module tb_mem_stage;

  localparam logic [6:0] c_load  = 7'b0000011;
  localparam logic [6:0] c_store = 7'b0100011;
  localparam logic [6:0] c_alu   = 7'b0110011;

  logic        Clock, Reset_n;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct;
  logic [31:0] in_alu_out, in_rs2_data;
  logic [4:0]  in_rd;
  logic [31:0] dcache_addr, dcache_din, dcache_dout;
  logic        dcache_re, dcache_stall;
  logic [3:0]  dcache_we;
  logic        wb_valid, wb_we, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int passed = 0;

  typedef struct {
    int          lat;
    int          re_cnt;
    int          we_cnt;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mis;
    logic        pulse_after;
  } obs_t;

  mem_stage #(.XLEN(32)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_alu_out(in_alu_out),
    .in_rs2_data(in_rs2_data), .in_rd(in_rd), .dcache_addr(dcache_addr),
    .dcache_re(dcache_re), .dcache_we(dcache_we), .dcache_din(dcache_din),
    .dcache_dout(dcache_dout), .dcache_stall(dcache_stall), .wb_valid(wb_valid),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: access size from funct3, legality, lane selection by arithmetic
  function automatic bit model_fault(bit st, logic [2:0] f3, logic [31:0] a);
    bit bad;
    logic [31:0] size;
    bad  = (f3[1:0] == 2'b11) || (st && f3[2]) || (!st && f3 == 3'b110);
    size = 32'd1 << f3[1:0];
    return bad || ((a % size) != 32'd0);
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    logic [31:0] v, b, h;
    v = d >> (8 * (a % 4));
    b = v % 32'd256;
    h = v % 32'd65536;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(logic [2:0] f3, logic [31:0] a);
    int bytes;
    bytes = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return 4'(((1 << bytes) - 1) << (a % 4));
  endfunction

  // Drives one instruction and records what the DUT does; comparisons stay in the callers.
  task automatic drive_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] dout,
                          input int rs, input int ws, output obs_t o);
    bit is_ld;
    is_ld = (op == c_load);
    o = '{default: 0};
    in_opcode = op; in_funct = f3; in_alu_out = addr; in_rs2_data = rs2; in_rd = rd;
    dcache_dout = dout; dcache_stall = 1'b0; in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (dcache_re) o.re_cnt++;
      if (dcache_we != 4'b0000) o.we_cnt++;
      if (c == 1) begin o.addr = dcache_addr; o.we = dcache_we; o.din = dcache_din; end
      if (wb_valid) begin
        o.lat = c; o.wb_we = wb_we; o.wb_rd = wb_rd; o.wb_data = wb_data; o.mis = misalign;
        break;
      end
      dcache_stall = (c <= rs) || (is_ld && c >= rs + 2 && c <= rs + 1 + ws);
      @(negedge Clock);
    end
    dcache_stall = 1'b0;
    @(negedge Clock);
    o.pulse_after = wb_valid | misalign;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct = '0; in_alu_out = '0;
    in_rs2_data = '0; in_rd = '0; dcache_dout = '0; dcache_stall = 1'b0;
    repeat (2) @(negedge Clock);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
    checks++; if ({wb_valid, wb_we, misalign, dcache_re} !== 4'b0) $display("FAIL reset_strobes got=%b exp=0000", {wb_valid, wb_we, misalign, dcache_re}); else passed++;
    checks++; if ({dcache_we, dcache_addr, dcache_din, wb_data, wb_rd} !== '0) $display("FAIL reset_buses got=%h/%h/%h/%h exp=0", dcache_we, dcache_addr, dcache_din, wb_data); else passed++;
    Reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", in_ready); else passed++;
    @(negedge Clock);
  endtask

  task automatic test_alu;
    obs_t o;
    drive_op(c_alu, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 0, 0, o);
    checks++; if (o.lat !== 1) $display("FAIL add_latency got=%0d exp=1", o.lat); else passed++;
    checks++; if ({o.wb_we, o.wb_rd, o.wb_data} !== {1'b1, 5'd5, 32'h0000_1234}) $display("FAIL add_wb got we=%b rd=%0d data=%h exp we=1 rd=5 data=00001234", o.wb_we, o.wb_rd, o.wb_data); else passed++;
    checks++; if (o.pulse_after !== 1'b0) $display("FAIL add_pulse got=%b exp=0", o.pulse_after); else passed++;
  endtask

  task automatic test_store;
    obs_t o;
    drive_op(c_store, 3'd0, 32'h103, 32'h0000_00AB, 5'd3, 32'h0, 0, 0, o);
    checks++; if (o.addr !== 32'h100) $display("FAIL sb_addr got=%h exp=00000100", o.addr); else passed++;
    checks++; if (o.we !== 4'b1000) $display("FAIL sb_we got=%b exp=1000", o.we); else passed++;
    checks++; if (o.din !== 32'hAB00_0000) $display("FAIL sb_din got=%h exp=ab000000", o.din); else passed++;
    checks++; if (o.lat !== 2 || o.wb_we !== 1'b0) $display("FAIL sb_done got lat=%0d we=%b exp lat=2 we=0", o.lat, o.wb_we); else passed++;
    checks++; if (o.we_cnt !== 1 || o.re_cnt !== 0) $display("FAIL sb_strobes got we=%0d re=%0d exp 1/0", o.we_cnt, o.re_cnt); else passed++;
  endtask

  task automatic test_load;
    obs_t o;
    drive_op(c_load, 3'd0, 32'h102, 32'h0, 5'd7, 32'h0080_0000, 0, 3, o);
    checks++; if (o.lat !== 6) $display("FAIL lb_latency got=%0d exp=6", o.lat); else passed++;
    checks++; if (o.wb_data !== 32'hFFFF_FF80 || o.wb_we !== 1'b1) $display("FAIL lb_data got=%h we=%b exp=ffffff80 we=1", o.wb_data, o.wb_we); else passed++;
    checks++; if (o.addr !== 32'h100 || o.re_cnt !== 1) $display("FAIL lb_req got addr=%h re=%0d exp 00000100/1", o.addr, o.re_cnt); else passed++;
    drive_op(c_load, 3'd4, 32'h102, 32'h0, 5'd7, 32'h0080_0000, 0, 3, o);
    checks++; if (o.wb_data !== 32'h0000_0080) $display("FAIL lbu_data got=%h exp=00000080", o.wb_data); else passed++;
    drive_op(c_load, 3'd5, 32'h2, 32'h0, 5'd0, 32'hBEEF_0000, 0, 0, o);
    checks++; if (o.wb_data !== 32'h0000_BEEF || o.wb_we !== 1'b0) $display("FAIL lhu_rd0 got=%h we=%b exp=0000beef we=0", o.wb_data, o.wb_we); else passed++;
    checks++; if (o.lat !== 3) $display("FAIL lhu_latency got=%0d exp=3", o.lat); else passed++;
  endtask

  task automatic test_misalign;
    obs_t o;
    drive_op(c_load, 3'd2, 32'h202, 32'h0, 5'd9, 32'h1234_5678, 0, 0, o);
    checks++; if (o.re_cnt !== 0) $display("FAIL lw_mis_re got=%0d exp=0", o.re_cnt); else passed++;
    checks++; if ({o.mis, o.wb_we} !== 2'b10 || o.lat !== 1) $display("FAIL lw_mis_wb got mis=%b we=%b lat=%0d exp 1/0/1", o.mis, o.wb_we, o.lat); else passed++;
    checks++; if (o.pulse_after !== 1'b0) $display("FAIL lw_mis_pulse got=%b exp=0", o.pulse_after); else passed++;
    drive_op(c_store, 3'd1, 32'h101, 32'hFFFF, 5'd1, 32'h0, 0, 0, o);
    checks++; if (o.we_cnt !== 0 || o.mis !== 1'b1) $display("FAIL sh_mis got we_cnt=%0d mis=%b exp 0/1", o.we_cnt, o.mis); else passed++;
    drive_op(c_load, 3'd3, 32'h100, 32'h0, 5'd2, 32'h0, 0, 0, o);
    checks++; if (o.re_cnt !== 0 || o.mis !== 1'b1 || o.lat !== 1) $display("FAIL undef_f3 got re=%0d mis=%b lat=%0d exp 0/1/1", o.re_cnt, o.mis, o.lat); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready); else passed++;
      if (i > 0) begin
        checks++; if (wb_valid !== 1'b1 || wb_data !== vals[i-1]) $display("FAIL b2b_wb[%0d] got v=%b d=%h exp v=1 d=%h", i, wb_valid, wb_data, vals[i-1]); else passed++;
      end
      in_opcode = c_alu; in_alu_out = vals[i]; in_rd = 5'(i + 1); in_valid = 1'b1;
      @(negedge Clock);
    end
    in_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== vals[3] || wb_rd !== 5'd4) $display("FAIL b2b_last got v=%b d=%h rd=%0d exp 1/%h/4", wb_valid, wb_data, wb_rd, vals[3]); else passed++;
    @(negedge Clock);
    checks++; if (wb_valid !== 1'b0 || wb_data !== vals[3]) $display("FAIL b2b_hold got v=%b d=%h exp 0/%h", wb_valid, wb_data, vals[3]); else passed++;
  endtask

  task automatic test_reset_inflight;
    obs_t o;
    int wb_seen;
    // Load stalled in REQ, then reset mid-cycle
    in_opcode = c_load; in_funct = 3'd2; in_alu_out = 32'h400; in_rd = 5'd6; in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0; dcache_stall = 1'b1;
    checks++; if (dcache_re !== 1'b1) $display("FAIL rst_req_pre got=%b exp=1", dcache_re); else passed++;
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (dcache_re !== 1'b0) $display("FAIL rst_req_re got=%b exp=0", dcache_re); else passed++;
    Reset_n = 1'b1;
    @(negedge Clock);
    // Store stalled in REQ
    dcache_stall = 1'b0;
    in_opcode = c_store; in_funct = 3'd2; in_alu_out = 32'h404; in_rs2_data = 32'h55; in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0; dcache_stall = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (dcache_we !== 4'b0000) $display("FAIL rst_req_we got=%b exp=0000", dcache_we); else passed++;
    Reset_n = 1'b1;
    @(negedge Clock);
    // Load stalled in WAIT
    dcache_stall = 1'b0;
    in_opcode = c_load; in_funct = 3'd0; in_alu_out = 32'h408; in_valid = 1'b1;
    @(negedge Clock);
    in_valid = 1'b0;
    @(negedge Clock);
    dcache_stall = 1'b1;
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (dcache_re !== 1'b0 || wb_valid !== 1'b0) $display("FAIL rst_wait_out got re=%b v=%b exp 0/0", dcache_re, wb_valid); else passed++;
    Reset_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL rst_wait_idle got=%b exp=1", in_ready); else passed++;
    @(negedge Clock);
    dcache_stall = 1'b0;
    wb_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (wb_valid) wb_seen++;
      @(negedge Clock);
    end
    checks++; if (wb_seen !== 0) $display("FAIL rst_no_wb got=%0d exp=0", wb_seen); else passed++;
    drive_op(c_alu, 3'd0, 32'hCAFE_0001, 32'h0, 5'd11, 32'h0, 0, 0, o);
    checks++; if (o.lat !== 1 || o.wb_data !== 32'hCAFE_0001 || o.wb_rd !== 5'd11) $display("FAIL rst_next_add got lat=%0d d=%h rd=%0d exp 1/cafe0001/11", o.lat, o.wb_data, o.wb_rd); else passed++;
  endtask

  task automatic test_random;
    obs_t o;
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] addr, rs2, dout, e_data;
    logic [4:0] rd;
    int rs, ws, e_lat, e_re, e_wecnt;
    bit is_st, is_mem, flt, e_we, e_mis;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: begin op = 7'($urandom); while (op == c_load || op == c_store) op = 7'($urandom); end
        1: op = c_load;
        default: op = c_store;
      endcase
      f3 = 3'($urandom); addr = $urandom; rs2 = $urandom; dout = $urandom; rd = 5'($urandom);
      rs = $urandom_range(0, 3); ws = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) addr = addr & 32'hFFFF_FFFC;
      drive_op(op, f3, addr, rs2, rd, dout, rs, ws, o);
      is_st = (op == c_store); is_mem = is_st || (op == c_load);
      flt = is_mem && model_fault(is_st, f3, addr);
      e_re = 0; e_wecnt = 0; e_mis = 0; e_we = 0; e_data = addr;
      if (!is_mem) begin e_lat = 1; e_we = 1; end
      else if (flt) begin e_lat = 1; e_mis = 1; end
      else if (is_st) begin e_lat = rs + 2; e_wecnt = rs + 1; end
      else begin e_lat = rs + ws + 3; e_re = rs + 1; e_we = (rd != 5'd0); e_data = model_load(f3, addr, dout); end
      checks++; if (o.lat !== e_lat) $display("FAIL rnd%0d_lat op=%h f3=%0d got=%0d exp=%0d", n, op, f3, o.lat, e_lat); else passed++;
      checks++; if (o.wb_we !== e_we || o.mis !== e_mis) $display("FAIL rnd%0d_flags got we=%b mis=%b exp we=%b mis=%b", n, o.wb_we, o.mis, e_we, e_mis); else passed++;
      checks++; if (o.re_cnt !== e_re || o.we_cnt !== e_wecnt) $display("FAIL rnd%0d_strobes got re=%0d we=%0d exp re=%0d we=%0d", n, o.re_cnt, o.we_cnt, e_re, e_wecnt); else passed++;
      checks++; if (o.pulse_after !== 1'b0) $display("FAIL rnd%0d_pulse got=%b exp=0", n, o.pulse_after); else passed++;
      if (!is_mem || (!flt && !is_st)) begin
        checks++; if (o.wb_data !== e_data || o.wb_rd !== rd) $display("FAIL rnd%0d_wb got d=%h rd=%0d exp d=%h rd=%0d", n, o.wb_data, o.wb_rd, e_data, rd); else passed++;
      end
      if (is_mem && !flt) begin
        checks++; if (o.addr !== (addr & 32'hFFFF_FFFC)) $display("FAIL rnd%0d_addr got=%h exp=%h", n, o.addr, addr & 32'hFFFF_FFFC); else passed++;
      end
      if (is_st && !flt) begin
        checks++; if (o.we !== model_mask(f3, addr) || o.din !== (rs2 << (8 * (addr % 4)))) $display("FAIL rnd%0d_store got we=%b din=%h exp we=%b din=%h", n, o.we, o.din, model_mask(f3, addr), rs2 << (8 * (addr % 4))); else passed++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d/%0d checks", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_misalign();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
